// File: rtl/bp_cfg_profile_bank.sv
// Runtime bank of configuration profiles; one profile drives the live config vector.
// Optional quiesce timeout: define BP_CFG_QUIESCE_TIMEOUT_EN.
module bp_cfg_profile_bank #(
    parameter int unsigned num_profiles_p  = 4,
    parameter int unsigned num_fields_p    = 16,
    parameter int unsigned field_width_p   = 32,
    parameter logic [num_fields_p*field_width_p-1:0] reset_cfg_p = '0,
    parameter int unsigned reset_profile_p = 0,
    parameter int unsigned timeout_p       = 64
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    w_v_i,
    input  logic [$clog2(num_profiles_p)-1:0]       w_profile_i,
    input  logic [$clog2(num_fields_p)-1:0]         w_field_i,
    input  logic [field_width_p-1:0]                w_data_i,
    output logic                                    w_ready_o,
    input  logic                                    r_v_i,
    input  logic [$clog2(num_profiles_p)-1:0]       r_profile_i,
    input  logic [$clog2(num_fields_p)-1:0]         r_field_i,
    output logic                                    r_v_o,
    output logic [field_width_p-1:0]                r_data_o,
    input  logic                                    switch_v_i,
    input  logic [$clog2(num_profiles_p)-1:0]       switch_profile_i,
    output logic                                    switch_ready_o,
    output logic                                    switch_done_o,
    output logic                                    switch_err_o,
    output logic                                    quiesce_req_o,
    input  logic                                    quiesce_ack_i,
    output logic [$clog2(num_profiles_p)-1:0]       active_profile_o,
    output logic [num_fields_p*field_width_p-1:0]   active_cfg_o,
    output logic                                    cfg_update_o
);

    localparam int unsigned pw_lp = $clog2(num_profiles_p);

    typedef enum logic [1:0] {e_ready, e_drain, e_swap, e_done} state_e;

    state_e state_q, state_d;

    logic [num_fields_p-1:0][field_width_p-1:0] mem_q [num_profiles_p];
    logic [num_fields_p-1:0][field_width_p-1:0] active_cfg_q;
    logic [pw_lp-1:0]         active_q;
    logic [pw_lp-1:0]         target_q;
    logic                     r_v_q;
    logic [field_width_p-1:0] r_data_q;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic switch_fire;
    logic sw_in_range;
    logic w_fire;
    logic w_in_range;
    logic r_in_range;
    logic timeout_hit;

    assign switch_fire = switch_v_i && (state_q == e_ready);
    assign sw_in_range = 32'(switch_profile_i) < num_profiles_p;
    assign w_fire      = w_v_i && w_ready_o;
    assign w_in_range  = (32'(w_profile_i) < num_profiles_p) && (32'(w_field_i) < num_fields_p);
    assign r_in_range  = (32'(r_profile_i) < num_profiles_p) && (32'(r_field_i) < num_fields_p);

`ifdef BP_CFG_QUIESCE_TIMEOUT_EN
    localparam int unsigned cw_lp = $clog2(timeout_p) + 1;

    logic [cw_lp-1:0] tmo_cnt_q;

    // Held at zero outside e_drain so it reads zero on the first drain cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q != e_drain) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + cw_lp'(1);
        end
    end

    assign timeout_hit = (state_q == e_drain) && (32'(tmo_cnt_q) == timeout_p - 1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            e_ready: begin
                if (switch_fire && sw_in_range && (switch_profile_i != active_q)) begin
                    state_d = e_drain;
                end
            end
            e_drain: begin
                // Ack wins over a coincident timeout.
                if (quiesce_ack_i) begin
                    state_d = e_swap;
                end else if (timeout_hit) begin
                    state_d = e_ready;
                end
            end
            e_swap:  state_d = e_done;
            e_done:  state_d = e_ready;
            default: state_d = e_ready;
        endcase
    end

    always_comb begin
        switch_ready_o   = (state_q == e_ready);
        quiesce_req_o    = (state_q == e_drain) || (state_q == e_swap);
        cfg_update_o     = (state_q == e_done);
        switch_done_o    = (state_q == e_done) || done_q;
        switch_err_o     = err_q;
        w_ready_o        = !((w_profile_i == active_q) ||
                             ((state_q != e_ready) && (w_profile_i == target_q)));
        r_v_o            = r_v_q;
        r_data_o         = r_data_q;
        active_profile_o = active_q;
        active_cfg_o     = active_cfg_q;
        done_d           = switch_fire && sw_in_range && (switch_profile_i == active_q);
        err_d            = (switch_fire && !sw_in_range) ||
                           ((state_q == e_drain) && !quiesce_ack_i && timeout_hit);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned p = 0; p < num_profiles_p; p++) begin
                mem_q[p] <= reset_cfg_p;
            end
            active_cfg_q <= reset_cfg_p;
            active_q     <= pw_lp'(reset_profile_p);
            target_q     <= '0;
            r_v_q        <= 1'b0;
            r_data_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (w_fire && w_in_range) begin
                mem_q[w_profile_i][w_field_i] <= w_data_i;
            end
            r_v_q <= r_v_i;
            if (r_v_i) begin
                r_data_q <= r_in_range ? mem_q[r_profile_i][r_field_i] : '0;
            end
            done_q <= done_d;
            err_q  <= err_d;
            if (switch_fire) begin
                target_q <= switch_profile_i;
            end
            // Target is write-protected from latch onward, so this snapshot is final.
            if (state_q == e_swap) begin
                active_q     <= target_q;
                active_cfg_q <= mem_q[target_q];
            end
        end
    end

endmodule

// File: tb/tb_bp_cfg_profile_bank.sv
// Scoreboard bench for bp_cfg_profile_bank (5 profiles so index 5+ is out of range).
module tb_bp_cfg_profile_bank;

    localparam int NP  = 5;
    localparam int NF  = 16;
    localparam int FW  = 32;
    localparam int PW  = 3;
    localparam int FIW = 4;
    localparam logic [NF*FW-1:0] RC = {32'hDEAD_BEEF, 352'd0, 32'h0000_00A5, 96'd0};

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              w_v_i = 1'b0;
    logic [PW-1:0]     w_profile_i = '0;
    logic [FIW-1:0]    w_field_i = '0;
    logic [FW-1:0]     w_data_i = '0;
    logic              w_ready_o;
    logic              r_v_i = 1'b0;
    logic [PW-1:0]     r_profile_i = '0;
    logic [FIW-1:0]    r_field_i = '0;
    logic              r_v_o;
    logic [FW-1:0]     r_data_o;
    logic              switch_v_i = 1'b0;
    logic [PW-1:0]     switch_profile_i = '0;
    logic              switch_ready_o;
    logic              switch_done_o;
    logic              switch_err_o;
    logic              quiesce_req_o;
    logic              quiesce_ack_i = 1'b0;
    logic [PW-1:0]     active_profile_o;
    logic [NF*FW-1:0]  active_cfg_o;
    logic              cfg_update_o;

    bp_cfg_profile_bank #(
        .num_profiles_p (NP),
        .num_fields_p   (NF),
        .field_width_p  (FW),
        .reset_cfg_p    (RC),
        .reset_profile_p(0),
        .timeout_p      (64)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .w_v_i           (w_v_i),
        .w_profile_i     (w_profile_i),
        .w_field_i       (w_field_i),
        .w_data_i        (w_data_i),
        .w_ready_o       (w_ready_o),
        .r_v_i           (r_v_i),
        .r_profile_i     (r_profile_i),
        .r_field_i       (r_field_i),
        .r_v_o           (r_v_o),
        .r_data_o        (r_data_o),
        .switch_v_i      (switch_v_i),
        .switch_profile_i(switch_profile_i),
        .switch_ready_o  (switch_ready_o),
        .switch_done_o   (switch_done_o),
        .switch_err_o    (switch_err_o),
        .quiesce_req_o   (quiesce_req_o),
        .quiesce_ack_i   (quiesce_ack_i),
        .active_profile_o(active_profile_o),
        .active_cfg_o    (active_cfg_o),
        .cfg_update_o    (cfg_update_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [FW-1:0] data;
        int            cyc;
    } rd_t;

    rd_t             rdq[$];
    logic [FW-1:0]   model [NP][NF];
    logic [NF-1:0][FW-1:0] act_v;
    int n_checks = 0;
    int n_fail   = 0;

    assign act_v = active_cfg_o;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        logic [NF*FW-1:0] rc_v;
        rc_v = RC;
        for (int p = 0; p < NP; p++)
            for (int f = 0; f < NF; f++)
                model[p][f] = rc_v[f*FW +: FW];
    endtask

    function automatic logic [FW-1:0] mval(input int p, input int f);
        if (p < NP && f < NF) return model[p][f];
        return '0;
    endfunction

    task automatic push_rd(input int p, input int f);
        rd_t e;
        e.data = mval(p, f);
        e.cyc  = cyc + 1;
        rdq.push_back(e);
    endtask

    task automatic rd(input int p, input int f);
        r_v_i = 1'b1;
        r_profile_i = PW'(p);
        r_field_i = FIW'(f);
        push_rd(p, f);
        tick();
        r_v_i = 1'b0;
    endtask

    task automatic wr(input int p, input int f, input logic [FW-1:0] d, input bit exp_rdy, input string tag);
        w_v_i = 1'b1;
        w_profile_i = PW'(p);
        w_field_i = FIW'(f);
        w_data_i = d;
        #1;
        check_eq(tag, w_ready_o, exp_rdy);
        if (exp_rdy && p < NP) model[p][f] = d;
        tick();
        w_v_i = 1'b0;
    endtask

    task automatic check_active_cfg(input int p);
        for (int f = 0; f < NF; f++)
            check_eq("act_cfg", act_v[f], model[p][f]);
    endtask

    // Drives one switch request and follows it until done/err (bounded).
    task automatic do_switch(input int p, input int ack_dly, input bit wr_en, input int wf,
                             input logic [FW-1:0] wd, output int lat, output int ndone,
                             output int nerr, output int nupd, output int nq);
        logic [NF*FW-1:0] prev;
        int qc;
        int stray;
        bit acked;
        bit fin;
        lat = -1; ndone = 0; nerr = 0; nupd = 0; nq = 0;
        qc = 0; stray = 0; acked = 1'b0; fin = 1'b0;
        switch_v_i = 1'b1;
        switch_profile_i = PW'(p);
        if (wr_en) begin
            w_v_i = 1'b1;
            w_profile_i = PW'(p);
            w_field_i = FIW'(wf);
            w_data_i = wd;
            #1;
            check_eq("wr_with_sw", w_ready_o, 1);
            if (p < NP) model[p][wf] = wd;
        end
        prev = active_cfg_o;
        tick();
        switch_v_i = 1'b0;
        w_v_i = 1'b0;
        for (int i = 1; i <= 200 && !fin; i++) begin
            ndone += int'(switch_done_o);
            nerr  += int'(switch_err_o);
            nupd  += int'(cfg_update_o);
            nq    += int'(quiesce_req_o);
            if (active_cfg_o !== prev && !cfg_update_o) stray++;
            prev = active_cfg_o;
            if (switch_done_o || switch_err_o) begin
                lat = i;
                fin = 1'b1;
            end else begin
                if (quiesce_req_o && !acked) begin
                    if (qc == ack_dly) begin
                        quiesce_ack_i = 1'b1;
                        acked = 1'b1;
                    end else begin
                        qc++;
                    end
                end
                tick();
                quiesce_ack_i = 1'b0;
            end
        end
        tick();
        ndone += int'(switch_done_o);
        nerr  += int'(switch_err_o);
        nupd  += int'(cfg_update_o);
        nq    += int'(quiesce_req_o);
        if (active_cfg_o !== prev) stray++;
        check_eq("cfg_stable", stray, 0);
    endtask

    always @(negedge clk_i) begin
        if (reset_n_i && r_v_o) begin
            if (rdq.size() == 0) begin
                check_eq("rd_unexpected", 1, 0);
            end else begin
                rd_t e;
                e = rdq.pop_front();
                check_eq("rd_data", r_data_o, e.data);
                check_eq("rd_lat", cyc, e.cyc);
            end
        end
    end

    initial begin
        int lat, nd, ne, nu, nq;
        model_reset();
        w_profile_i = 3'd1;
        repeat (3) tick();
        check_eq("rst_w_ready", w_ready_o, 1);
        check_eq("rst_sw_ready", switch_ready_o, 1);
        check_eq("rst_quiesce", quiesce_req_o, 0);
        check_eq("rst_done", switch_done_o, 0);
        check_eq("rst_err", switch_err_o, 0);
        check_eq("rst_upd", cfg_update_o, 0);
        check_eq("rst_rv", r_v_o, 0);
        check_eq("rst_active", active_profile_o, 0);
        reset_n_i = 1'b1;
        tick();
        check_active_cfg(0);

        for (int p = 0; p < NP; p++) rd(p, 3);
        rd(4, 15);
        rd(5, 3);
        rd(6, 15);

        wr(0, 3, 32'hFFFF_FFFF, 0, "wr_active_blk");
        rd(0, 3);

        wr(1, 2, 32'h1234, 1, "wr_p1");
        do_switch(1, 2, 0, 0, '0, lat, nd, ne, nu, nq);
        check_eq("sw1_lat", lat, 5);
        check_eq("sw1_done", nd, 1);
        check_eq("sw1_err", ne, 0);
        check_eq("sw1_upd", nu, 1);
        check_eq("sw1_quiesce", nq, 4);
        check_eq("sw1_active", active_profile_o, 1);
        check_eq("sw1_f2", act_v[2], 32'h1234);
        check_active_cfg(1);

        quiesce_ack_i = 1'b1;
        tick();
        quiesce_ack_i = 1'b0;
        check_eq("ack_ignored", quiesce_req_o, 0);

        wr(3, 7, 32'h77, 1, "wr_p3");
        switch_v_i = 1'b1;
        switch_profile_i = 3'd3;
        tick();
        switch_v_i = 1'b0;
        check_eq("drain_q", quiesce_req_o, 1);
        check_eq("drain_sw_ready", switch_ready_o, 0);
        wr(3, 4, 32'h3333, 0, "wr_target_blk");
        wr(1, 4, 32'h1111, 0, "wr_active_blk1");
        wr(0, 5, 32'hBEEF, 1, "wr_other_ok");
        check_eq("drain_hold", quiesce_req_o, 1);
        quiesce_ack_i = 1'b1;
        tick();
        quiesce_ack_i = 1'b0;
        check_eq("swap_q", quiesce_req_o, 1);
        check_eq("swap_active", active_profile_o, 1);
        check_eq("swap_upd", cfg_update_o, 0);
        tick();
        check_eq("done3", switch_done_o, 1);
        check_eq("upd3", cfg_update_o, 1);
        check_eq("q3", quiesce_req_o, 0);
        check_eq("active3", active_profile_o, 3);
        check_active_cfg(3);
        rd(3, 4);
        rd(1, 4);
        rd(0, 5);

        do_switch(3, 0, 0, 0, '0, lat, nd, ne, nu, nq);
        check_eq("same_lat", lat, 1);
        check_eq("same_done", nd, 1);
        check_eq("same_upd", nu, 0);
        check_eq("same_q", nq, 0);
        do_switch(5, 0, 0, 0, '0, lat, nd, ne, nu, nq);
        check_eq("oor5_lat", lat, 1);
        check_eq("oor5_err", ne, 1);
        check_eq("oor5_done", nd, 0);
        check_eq("oor5_q", nq, 0);
        check_eq("oor5_active", active_profile_o, 3);
        do_switch(7, 0, 0, 0, '0, lat, nd, ne, nu, nq);
        check_eq("oor7_err", ne, 1);

        do_switch(2, 1, 1, 0, 32'd7, lat, nd, ne, nu, nq);
        check_eq("sw2_lat", lat, 4);
        check_eq("sw2_done", nd, 1);
        check_eq("sw2_q", nq, 3);
        check_eq("sw2_f0", act_v[0], 32'd7);
        check_active_cfg(2);

        r_v_i = 1'b1;
        r_profile_i = 3'd0;
        r_field_i = 4'd5;
        push_rd(0, 5);
        wr(0, 5, 32'hCAFE, 1, "wr_rw");
        r_v_i = 1'b0;
        rd(0, 5);

`ifdef BP_CFG_QUIESCE_TIMEOUT_EN
        do_switch(0, 1000, 0, 0, '0, lat, nd, ne, nu, nq);
        check_eq("tmo_lat", lat, 65);
        check_eq("tmo_err", ne, 1);
        check_eq("tmo_done", nd, 0);
        check_eq("tmo_upd", nu, 0);
        check_eq("tmo_q", nq, 64);
        check_eq("tmo_active", active_profile_o, 2);
        do_switch(0, 63, 0, 0, '0, lat, nd, ne, nu, nq);
        check_eq("tmo_ack_lat", lat, 66);
        check_eq("tmo_ack_done", nd, 1);
        check_eq("tmo_ack_err", ne, 0);
        check_eq("tmo_ack_active", active_profile_o, 0);
`endif

        switch_v_i = 1'b1;
        switch_profile_i = 3'd4;
        tick();
        switch_v_i = 1'b0;
        tick();
        check_eq("mid_q", quiesce_req_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("mid_rst_q", quiesce_req_o, 0);
        check_eq("mid_rst_active", active_profile_o, 0);
        model_reset();
        tick();
        reset_n_i = 1'b1;
        begin
            int pulses = 0;
            for (int i = 0; i < 6; i++) begin
                pulses += int'(switch_done_o) + int'(switch_err_o) + int'(cfg_update_o);
                tick();
            end
            check_eq("mid_rst_pulses", pulses, 0);
        end
        rd(1, 2);
        rd(2, 3);

        repeat (3) tick();
        check_eq("rdq_empty", rdq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
